mem_port_arbiter: RTL and testbench

Shares the single-ported, fixed-latency main memory between the instruction-fetch port and the data-access port of the pipelined CPU. It sequences each access over `LATENCY` cycles and holds the memory address, command and write data stable for that whole access. It returns read data with a one-cycle ready pulse, and drives the per-port stall flags consumed by the hazard logic. Data accesses have priority, bounded by a starvation limit so instruction fetch always makes progress.

---
 rtl/mem_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared fixed-latency memory between instruction fetch and data access.
// Data accesses win by default; a streak limit guarantees fetch progress.
module mem_port_arbiter #(
  parameter int LATENCY      = 4,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MAX_D_STREAK = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_cancel,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_data,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W  = $clog2(LATENCY);
  localparam int STRK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LATENCY - 1);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_I_BUSY = 2'd1,
    ST_D_BUSY = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [STRK_W-1:0]   r_streak, w_streak_nxt;
  logic                r_discard, w_discard_nxt;
  logic                r_mem_read, w_mem_read_nxt;
  logic                r_mem_write, w_mem_write_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic                r_i_ready, w_i_ready_nxt;
  logic                r_d_ready, w_d_ready_nxt;
  logic [DATA_W-1:0]   r_i_data, w_i_data_nxt;
  logic [DATA_W-1:0]   r_d_rdata, w_d_rdata_nxt;

  logic                w_dv;
  logic                w_iv;
  logic                w_last;

  // A port is not re-arbitrated in the cycle its ready pulse is visible.
  assign w_dv   = d_req & ~r_d_ready;
  assign w_iv   = i_req & ~r_i_ready & ~i_cancel;
  assign w_last = (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_streak_nxt    = r_streak;
    w_discard_nxt   = r_discard;
    w_mem_read_nxt  = r_mem_read;
    w_mem_write_nxt = r_mem_write;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_i_ready_nxt   = 1'b0;
    w_d_ready_nxt   = 1'b0;
    w_i_data_nxt    = r_i_data;
    w_d_rdata_nxt   = r_d_rdata;

    case (r_state)
      ST_IDLE: begin
        if (w_dv && w_iv && (r_streak == STRK_MAX)) begin
          w_state_nxt     = ST_I_BUSY;
          w_mem_addr_nxt  = i_addr;
          w_mem_read_nxt  = 1'b1;
          w_mem_write_nxt = 1'b0;
          w_cnt_nxt       = '0;
          w_streak_nxt    = '0;
          w_discard_nxt   = 1'b0;
        end else if (w_dv) begin
          w_state_nxt     = ST_D_BUSY;
          w_mem_addr_nxt  = d_addr;
          w_mem_wdata_nxt = d_wdata;
          w_mem_read_nxt  = ~d_we;
          w_mem_write_nxt = d_we;
          w_cnt_nxt       = '0;
          // Cannot pass STRK_MAX: at the limit with a waiting fetch, I wins above.
          w_streak_nxt    = w_iv ? (r_streak + STRK_W'(1)) : '0;
        end else if (w_iv) begin
          w_state_nxt     = ST_I_BUSY;
          w_mem_addr_nxt  = i_addr;
          w_mem_read_nxt  = 1'b1;
          w_mem_write_nxt = 1'b0;
          w_cnt_nxt       = '0;
          w_streak_nxt    = '0;
          w_discard_nxt   = 1'b0;
        end
      end

      ST_I_BUSY: begin
        if (w_last) begin
          w_i_data_nxt   = mem_rdata;
          w_mem_read_nxt = 1'b0;
          w_state_nxt    = ST_IDLE;
          // The memory cannot abort, so a cancelled fetch just loses its pulse.
          w_i_ready_nxt  = ~(r_discard | i_cancel);
          w_discard_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (i_cancel) begin
            w_discard_nxt = 1'b1;
          end
        end
      end

      ST_D_BUSY: begin
        if (w_last) begin
          if (r_mem_read) begin
            w_d_rdata_nxt = mem_rdata;
          end
          w_mem_read_nxt  = 1'b0;
          w_mem_write_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
          w_d_ready_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_mem_read_nxt  = 1'b0;
        w_mem_write_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_streak    <= '0;
      r_discard   <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_ready   <= 1'b0;
      r_d_ready   <= 1'b0;
      r_i_data    <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_streak    <= w_streak_nxt;
      r_discard   <= w_discard_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_i_ready   <= w_i_ready_nxt;
      r_d_ready   <= w_d_ready_nxt;
      r_i_data    <= w_i_data_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
    end
  end

  assign i_ready   = r_i_ready;
  assign i_data    = r_i_data;
  assign i_stall   = i_req & ~r_i_ready;
  assign d_ready   = r_d_ready;
  assign d_rdata   = r_d_rdata;
  assign d_stall   = d_req & ~r_d_ready;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: load, store, priority, streak limit, cancel, reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req, i_cancel, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_ready, i_stall, d_ready, d_stall, mem_read, mem_write;
  logic [15:0] i_data, d_rdata, mem_addr, mem_wdata, mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] rd_age = 4'd0;
  logic       act_q  = 1'b0;
  byte        glog[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.LATENCY(4), .ADDR_W(16), .DATA_W(16), .MAX_D_STREAK(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel),
    .i_ready(i_ready), .i_data(i_data), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: data is only valid in the fourth cycle of a read.
  always @(posedge clk) rd_age <= mem_read ? rd_age + 4'd1 : 4'd0;
  assign mem_rdata = (mem_read && rd_age == 4'd3) ?
                     ((mem_addr == 16'h0010) ? 16'h1234 : (mem_addr ^ 16'hA5A5)) : 16'hDEAD;

  // Grant log: 'D' for 0x02xx addresses, 'I' otherwise.
  always @(negedge clk) begin
    if ((mem_read | mem_write) && !act_q) glog.push_back(mem_addr[9] ? 8'h44 : 8'h49);
    act_q <= mem_read | mem_write;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; i_req = 1'b0; i_cancel = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) step();
    #1;
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_i_ready", i_ready, 0);
    check("rst_d_ready", d_ready, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_i_data", i_data, 0);
    reset_n = 1'b1;
    step();

    // Data load
    step(); d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010; #1;
    check("ld_c0_stall", d_stall, 1);
    check("ld_c0_read", mem_read, 0);
    for (int k = 1; k <= 4; k++) begin
      step(); #1;
      check("ld_read", mem_read, 1);
      check("ld_addr", mem_addr, 16'h0010);
      check("ld_noready", d_ready, 0);
      check("ld_stall", d_stall, 1);
    end
    step(); #1;
    check("ld_ready", d_ready, 1);
    check("ld_rdata", d_rdata, 16'h1234);
    check("ld_stall_low", d_stall, 0);
    check("ld_read_off", mem_read, 0);
    step(); d_req = 1'b0; #1;
    check("ld_pulse_one", d_ready, 0);

    // Store
    step(); d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'hBEEF; #1;
    for (int k = 1; k <= 4; k++) begin
      step(); #1;
      check("st_write", mem_write, 1);
      check("st_noread", mem_read, 0);
      check("st_addr", mem_addr, 16'h0020);
      check("st_wdata", mem_wdata, 16'hBEEF);
    end
    step(); #1;
    check("st_ready", d_ready, 1);
    check("st_write_off", mem_write, 0);
    check("st_rdata_kept", d_rdata, 16'h1234);
    step(); d_req = 1'b0; d_we = 1'b0; #1;

    // Simultaneous requests: D first, I takes the D ready cycle
    step(); d_req = 1'b1; d_addr = 16'h0200; i_req = 1'b1; i_addr = 16'h0100; #1;
    for (int k = 1; k <= 4; k++) begin
      step(); #1;
      check("sim_d_addr", mem_addr, 16'h0200);
      check("sim_i_stall", i_stall, 1);
    end
    step(); #1;
    check("sim_d_ready", d_ready, 1);
    check("sim_d_rdata", d_rdata, 16'hA7A5);
    check("sim_i_wait", i_ready, 0);
    step(); d_req = 1'b0; #1;
    for (int k = 6; k <= 9; k++) begin
      check("sim_i_read", mem_read, 1);
      check("sim_i_addr", mem_addr, 16'h0100);
      step(); #1;
    end
    check("sim_i_ready", i_ready, 1);
    check("sim_i_data", i_data, 16'hA4A5);
    check("sim_i_stall_low", i_stall, 0);
    step(); i_req = 1'b0; #1;
    check("sim_i_pulse_one", i_ready, 0);

    // Streak limit: each port re-requests the cycle after any ready pulse
    begin
      bit done;
      done = 1'b0;
      glog.delete();
      step(); d_we = 1'b0; d_addr = 16'h0200; i_addr = 16'h0100; d_req = 1'b1; i_req = 1'b1;
      for (int c = 0; c < 200 && !done; c++) begin
        step();
        if (d_ready || i_ready) begin
          if (d_ready) d_addr = d_addr + 16'd1;
          if (i_ready) i_addr = i_addr + 16'd1;
          d_req = 1'b0; i_cancel = 1'b1;
          if (i_ready && glog.size() >= 6) done = 1'b1;
        end else begin
          d_req = 1'b1; i_cancel = 1'b0;
        end
      end
      check("strk_done", done, 1);
      d_req = 1'b0; i_req = 1'b0; i_cancel = 1'b0;
      check("strk_count", glog.size(), 6);
      for (int g = 0; g < 6; g++) begin
        byte exp_g;
        exp_g = (g == 2 || g == 5) ? 8'h49 : 8'h44;
        check("strk_order", (g < glog.size()) ? glog[g] : 8'h00, exp_g);
      end
      step(); step();
    end

    // Cancel during an I access
    step(); i_req = 1'b1; i_addr = 16'h0130; #1;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 2) i_cancel = 1'b1;
      if (k == 3) begin i_cancel = 1'b0; i_req = 1'b0; d_req = 1'b1; d_addr = 16'h0240; end
      #1;
      check("can_read_span", mem_read, 1);
      check("can_addr", mem_addr, 16'h0130);
    end
    for (int k = 5; k <= 10; k++) begin
      step(); #1;
      check("can_no_iready", i_ready, 0);
      if (k >= 6 && k <= 9) check("can_d_addr", mem_addr, 16'h0240);
    end
    check("can_d_ready", d_ready, 1);
    check("can_d_rdata", d_rdata, 16'hA7E5);
    step(); d_req = 1'b0; #1;

    // Cancel coinciding with I completion
    step(); i_req = 1'b1; i_addr = 16'h0150; #1;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 4) i_cancel = 1'b1;
      #1;
    end
    step(); i_cancel = 1'b0; i_req = 1'b0; #1;
    check("cancel_at_last", i_ready, 0);
    step(); #1;
    check("cancel_at_last_idle", mem_read, 0);

    // Reset in the middle of a data access
    step(); d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0260; #1;
    step(); step(); step(); reset_n = 1'b0; #1;
    check("rstm_busy", mem_read, 1);
    step(); d_req = 1'b0; #1;
    check("rstm_read", mem_read, 0);
    check("rstm_write", mem_write, 0);
    check("rstm_addr", mem_addr, 0);
    check("rstm_wdata", mem_wdata, 0);
    check("rstm_d_rdata", d_rdata, 0);
    check("rstm_d_ready", d_ready, 0);
    check("rstm_d_stall", d_stall, 0);
    step(); reset_n = 1'b1; #1;
    check("rstm_no_ready", d_ready, 0);
    step(); #1;
    check("rstm_no_ready2", d_ready, 0);
    step(); d_req = 1'b1; d_addr = 16'h0010; #1;
    for (int k = 1; k <= 4; k++) begin
      step(); #1;
      check("rstm_new_read", mem_read, 1);
    end
    step(); #1;
    check("rstm_new_ready", d_ready, 1);
    check("rstm_new_rdata", d_rdata, 16'h1234);
    step(); d_req = 1'b0; #1;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
